// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the shared multicycle MIPS datapath.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset to FETCH
//   op, funct, zero     IR opcode/function fields and ALU zero flag
//   pcen .. alucontrol  datapath enables and mux selects
//   illegal             one-cycle pulse on an unsupported op or funct
//   state               current state for debug
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur, nxt;
    logic   pcw, br, mw, irw, rw, ill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt        = FETCH;
        pcw        = 1'b0;
        br         = 1'b0;
        mw         = 1'b0;
        irw        = 1'b0;
        rw         = 1'b0;
        ill        = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (cur)
            FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irw        = 1'b1;
                pcw        = 1'b1;
                nxt        = DECODE;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      ill = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                nxt        = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                nxt  = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                rw       = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                nxt     = ALUWB;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        alucontrol = 3'b010;
                        ill        = 1'b1;
                        nxt        = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                br         = 1'b1;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                nxt        = ADDIWB;
            end
            ADDIWB: rw = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcw   = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked while reset is held so an aborted instruction cannot write anything.
    assign pcen     = (pcw | (br & zero)) & ~reset;
    assign memwrite = mw & ~reset;
    assign irwrite  = irw & ~reset;
    assign regwrite = rw & ~reset;
    assign illegal  = ill & ~reset;
    assign state    = STATE_W'(cur);
endmodule
